// File: rtl/arm_pkg.sv
// Shared fetch-stage constants, FSM encoding and PC helpers.
// Imported by the fetch unit and its PC register.
package arm_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'd0;
  localparam logic [31:0] NOP_INST_DEF  = 32'd0;
  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// 32-bit register with asynchronous active-high reset and load enable.
// Holds the fetch program counter.
module pc_reg
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] val_q;
  logic [31:0] val_d;

  always_comb begin
    val_d = val_q;
    if (en) val_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) val_q <= RESET_VAL;
    else     val_q <= val_d;
  end

  assign q = val_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC sequencing plus the IF/ID pipeline register.
// First edge after reset always loads a bubble.
module if_fetch_unit
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        flush,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_in,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        valid_out
);

  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  pc_d;
  logic         pc_en;

  fetch_state_e state_q, state_d;
  logic         load_bubble;
  logic         hold_ifid;

  logic [31:0]  pc_out_q, pc_out_d;
  logic [31:0]  inst_out_q, inst_out_d;
  logic         valid_out_q, valid_out_d;

  assign pc_plus4  = pc + PC_STEP;
  assign inst_addr = pc;

  // Branch beats freeze for the PC.
  always_comb begin
    pc_d  = pc_plus4;
    pc_en = 1'b1;
    if (branch_taken) pc_d = align_pc(branch_addr);
    else if (freeze)  pc_en = 1'b0;
  end

  pc_reg #(
    .RESET_VAL(RESET_PC)
  ) u_pc_reg (
    .clk(clk),
    .rst(rst),
    .en (pc_en),
    .d  (pc_d),
    .q  (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = (freeze && !branch_taken) ? ST_STALL : ST_RUN;
      ST_RUN:   if (freeze && !branch_taken) state_d = ST_STALL;
      ST_STALL: if (!freeze || branch_taken) state_d = ST_RUN;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    load_bubble = flush || branch_taken;
    hold_ifid   = freeze && !(flush || branch_taken);
    if (state_q == ST_BOOT) begin
      load_bubble = 1'b1;
      hold_ifid   = 1'b0;
    end
  end

  always_comb begin
    pc_out_d    = pc_out_q;
    inst_out_d  = inst_out_q;
    valid_out_d = valid_out_q;
    if (load_bubble) begin
      pc_out_d    = pc_plus4;
      inst_out_d  = NOP_INST;
      valid_out_d = 1'b0;
    end else if (!hold_ifid) begin
      pc_out_d    = pc_plus4;
      inst_out_d  = inst_in;
      valid_out_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out_q    <= 32'd0;
      inst_out_q  <= NOP_INST;
      valid_out_q <= 1'b0;
    end else begin
      pc_out_q    <= pc_out_d;
      inst_out_q  <= inst_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign pc_out    = pc_out_q;
  assign inst_out  = inst_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a
// randomized run against a behavioural fetch model.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'd0;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        flush;
  logic [31:0] inst_addr;
  logic [31:0] inst_in;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        valid_out;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] m_pc, m_pco, m_inst;
  logic        m_valid, m_boot;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .flush(flush), .inst_addr(inst_addr), .inst_in(inst_in),
    .pc_out(pc_out), .inst_out(inst_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'hE4923002;
    return (a * 32'h9E3779B1) ^ 32'h1357_9BDF;
  endfunction

  assign inst_in = mem_word(inst_addr);

  task automatic model_reset();
    m_pc = 32'd0; m_pco = 32'd0; m_inst = NOP;
    m_valid = 1'b0; m_boot = 1'b1;
  endtask

  // Advance model and DUT by one rising edge; returns #1 after the edge.
  task automatic step();
    logic [31:0] n_pc, n_pco, n_inst;
    logic        n_valid;
    n_pco = m_pco; n_inst = m_inst; n_valid = m_valid;
    if (m_boot || flush || branch_taken) begin
      n_pco = m_pc + 32'd4; n_inst = NOP; n_valid = 1'b0;
    end else if (!freeze) begin
      n_pco = m_pc + 32'd4; n_inst = mem_word(m_pc); n_valid = 1'b1;
    end
    if (branch_taken) n_pc = {branch_addr[31:2], 2'b00};
    else if (freeze)  n_pc = m_pc;
    else              n_pc = m_pc + 32'd4;
    @(posedge clk);
    m_pc = n_pc; m_pco = n_pco; m_inst = n_inst;
    m_valid = n_valid; m_boot = 1'b0;
    #1;
  endtask

  task automatic idle_inputs();
    freeze = 0; branch_taken = 0; flush = 0; branch_addr = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    n_total++;
    if ({inst_addr, pc_out, inst_out, valid_out} !== {32'd0, 32'd0, NOP, 1'b0})
      $display("FAIL reset_async: got addr=%h pc=%h inst=%h v=%b want 0/0/%h/0",
               inst_addr, pc_out, inst_out, valid_out, NOP);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) step();
    n_total++;
    if (inst_addr !== 32'd12) $display("FAIL reset_addr12: got %h want 0000000c", inst_addr);
    else n_pass++;
    n_total++;
    if (pc_out !== 32'd12) $display("FAIL reset_pcout12: got %h want 0000000c", pc_out);
    else n_pass++;
    n_total++;
    if (valid_out !== 1'b1) $display("FAIL reset_valid: got %b want 1", valid_out);
    else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    step();
    n_total++;
    if ({pc_out, inst_out, valid_out} !== {32'd4, NOP, 1'b0})
      $display("FAIL boot_bubble: got pc=%h inst=%h v=%b want 4/%h/0", pc_out, inst_out, valid_out, NOP);
    else n_pass++;
    step();
    n_total++;
    if ({pc_out, inst_out, valid_out} !== {32'd8, mem_word(32'd4), 1'b1})
      $display("FAIL stream_first: got pc=%h inst=%h v=%b want 8/%h/1", pc_out, inst_out, valid_out, mem_word(32'd4));
    else n_pass++;
    branch_taken = 1; branch_addr = 32'd0;
    step();
    idle_inputs();
    step();
    n_total++;
    if ({pc_out, inst_out, valid_out} !== {32'd4, 32'hE4923002, 1'b1})
      $display("FAIL stream_addr0: got pc=%h inst=%h v=%b want 4/e4923002/1", pc_out, inst_out, valid_out);
    else n_pass++;
  endtask

  task automatic test_freeze();
    do_reset();
    repeat (2) step();
    freeze = 1;
    repeat (2) begin
      step();
      n_total++;
      if (inst_addr !== 32'd8) $display("FAIL freeze_pc: got %h want 00000008", inst_addr);
      else n_pass++;
      n_total++;
      if ({pc_out, inst_out, valid_out} !== {32'd8, mem_word(32'd4), 1'b1})
        $display("FAIL freeze_ifid: got pc=%h inst=%h v=%b want 8/%h/1", pc_out, inst_out, valid_out, mem_word(32'd4));
      else n_pass++;
    end
    freeze = 0;
    step();
    n_total++;
    if (inst_addr !== 32'd12) $display("FAIL unfreeze_pc: got %h want 0000000c", inst_addr);
    else n_pass++;
    n_total++;
    if (inst_out !== mem_word(32'd8)) $display("FAIL unfreeze_inst: got %h want %h", inst_out, mem_word(32'd8));
    else n_pass++;
  endtask

  task automatic test_branch_over_freeze();
    do_reset();
    repeat (2) step();
    branch_taken = 1; freeze = 1; branch_addr = 32'h40;
    step();
    idle_inputs();
    n_total++;
    if ({inst_addr, inst_out, valid_out} !== {32'h40, NOP, 1'b0})
      $display("FAIL branch_freeze: got addr=%h inst=%h v=%b want 40/%h/0", inst_addr, inst_out, valid_out, NOP);
    else n_pass++;
    flush = 1; freeze = 1;
    step();
    idle_inputs();
    n_total++;
    if ({inst_addr, pc_out, inst_out, valid_out} !== {32'h40, 32'h44, NOP, 1'b0})
      $display("FAIL flush_freeze: got addr=%h pc=%h inst=%h v=%b want 40/44/%h/0",
               inst_addr, pc_out, inst_out, valid_out, NOP);
    else n_pass++;
  endtask

  task automatic test_wrap_align();
    do_reset();
    step();
    branch_taken = 1; branch_addr = 32'hFFFF_FFFC;
    step();
    idle_inputs();
    step();
    n_total++;
    if ({inst_addr, pc_out, inst_out} !== {32'd0, 32'd0, mem_word(32'hFFFF_FFFC)})
      $display("FAIL wrap: got addr=%h pc=%h inst=%h want 0/0/%h", inst_addr, pc_out, inst_out, mem_word(32'hFFFF_FFFC));
    else n_pass++;
    branch_taken = 1; branch_addr = 32'h43;
    step();
    idle_inputs();
    n_total++;
    if (inst_addr !== 32'h40) $display("FAIL align: got %h want 00000040", inst_addr);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    repeat (3) step();
    freeze = 1;
    step();
    #1;
    rst = 1'b1;
    #1;
    n_total++;
    if ({inst_addr, pc_out, inst_out, valid_out} !== {32'd0, 32'd0, NOP, 1'b0})
      $display("FAIL mid_reset: got addr=%h pc=%h inst=%h v=%b want 0/0/%h/0",
               inst_addr, pc_out, inst_out, valid_out, NOP);
    else n_pass++;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) step();
    n_total++;
    if ({inst_addr, pc_out, inst_out, valid_out} !== {32'd8, 32'd8, mem_word(32'd4), 1'b1})
      $display("FAIL restart: got addr=%h pc=%h inst=%h v=%b want 8/8/%h/1",
               inst_addr, pc_out, inst_out, valid_out, mem_word(32'd4));
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      freeze       = ($urandom_range(0, 99) < 30);
      branch_taken = ($urandom_range(0, 99) < 12);
      flush        = ($urandom_range(0, 99) < 12);
      branch_addr  = $urandom();
      step();
      errs = 0;
      n_total++;
      if (inst_addr !== m_pc) begin
        errs++;
        $display("FAIL rand_pc[%0d]: got %h want %h", i, inst_addr, m_pc);
      end else n_pass++;
      n_total++;
      if ({pc_out, inst_out, valid_out} !== {m_pco, m_inst, m_valid}) begin
        errs++;
        $display("FAIL rand_ifid[%0d]: got pc=%h inst=%h v=%b want %h/%h/%b",
                 i, pc_out, inst_out, valid_out, m_pco, m_inst, m_valid);
      end else n_pass++;
      if (errs != 0) break;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_freeze();
    test_branch_over_freeze();
    test_wrap_align();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
